fp_addsub_sequencer: RTL and testbench

Clocked issue/retire wrapper directly upstream and downstream of the combinational add_sub_top adder. It accepts two packed IEEE-754 single operands plus an opcode over a valid/ready handshake, unpacks them into registered sign/exponent/significand fields that drive the adder, and waits a fixed settle time. It then captures fp_out/error and presents the result over a second valid/ready handshake. NaN/Inf operands bypass the adder with IEEE results.

---
 rtl/addpkg.sv | 64 ++++++
 rtl/fp_classify.sv | 16 +
 rtl/fp_addsub_sequencer.sv | 121 ++++++++++++
 tb/tb_fp_addsub_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addpkg.sv
// Shared types, constants and the special-operand result function for the
// add/sub issue/retire sequencer.
package addpkg;

  localparam int          ERR_W   = 3;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] significand;
  } fp_unpkg_t;

  typedef union packed {
    logic [31:0] bits;
    fp_unpkg_t   unpkg;
  } fp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [31:0] bits;
    logic        invalid;
  } bypass_res_t;

  // B's sign is taken after the subtract flip, so Inf-Inf of equal signs
  // under subtraction lands on the invalid branch.
  function automatic bypass_res_t bypass_result(
    input fp_t  a,
    input fp_t  b,
    input logic opcode,
    input logic a_nan,
    input logic a_inf,
    input logic b_nan,
    input logic b_inf
  );
    bypass_res_t r;
    logic        eff_sb;
    eff_sb    = b.unpkg.sign ^ opcode;
    r.bits    = QNAN;
    r.invalid = 1'b1;
    if (!(a_nan || b_nan)) begin
      if (a_inf && b_inf) begin
        if (a.unpkg.sign == eff_sb) begin
          r.bits    = a.bits;
          r.invalid = 1'b0;
        end
      end else if (a_inf) begin
        r.bits    = a.bits;
        r.invalid = 1'b0;
      end else begin
        r.bits    = {eff_sb, EXP_MAX, 23'd0};
        r.invalid = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Flags an IEEE single operand as NaN or infinity.
module fp_classify
  import addpkg::*;
(
  input  fp_t  i_fp,
  output logic is_nan,
  output logic is_inf
);

  logic w_exp_max;

  assign w_exp_max = (i_fp.unpkg.exponent == EXP_MAX);
  assign is_nan    = w_exp_max && (i_fp.unpkg.significand != 23'd0);
  assign is_inf    = w_exp_max && (i_fp.unpkg.significand == 23'd0);

endmodule

// File: rtl/fp_addsub_sequencer.sv
// Issue/retire wrapper around the combinational add_sub_top adder: registers
// unpacked operands, waits a fixed settle time, then presents the result.
module fp_addsub_sequencer
  import addpkg::*;
#(
  parameter int SETTLE_CYCLES = 2
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  input  logic             in_opcode,
  output logic             sign1,
  output logic             sign2,
  output logic [7:0]       exp1,
  output logic [7:0]       exp2,
  output logic [22:0]      sig1,
  output logic [22:0]      sig2,
  output logic             opcode,
  input  logic [31:0]      fp_out,
  input  logic [ERR_W-1:0] error,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_bits,
  output logic [ERR_W-1:0] res_error,
  output logic             res_bypass,
  output logic             res_invalid,
  output seq_state_e       dbg_state
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  seq_state_e  r_state;
  seq_state_e  w_state_next;
  logic [3:0]  r_cnt;
  logic        w_accept;
  logic        w_retire;
  logic        w_bypass;
  logic        w_a_nan, w_a_inf, w_b_nan, w_b_inf;
  fp_t         w_a, w_b;
  bypass_res_t w_byp;

  assign w_a = fp_t'(op_a);
  assign w_b = fp_t'(op_b);

  fp_classify u_class_a (.i_fp(w_a), .is_nan(w_a_nan), .is_inf(w_a_inf));
  fp_classify u_class_b (.i_fp(w_b), .is_nan(w_b_nan), .is_inf(w_b_inf));

  assign w_bypass = w_a_nan | w_a_inf | w_b_nan | w_b_inf;
  assign w_byp    = bypass_result(w_a, w_b, in_opcode,
                                  w_a_nan, w_a_inf, w_b_nan, w_b_inf);

  // A transfer happens on a rising edge where valid and ready are both high;
  // the requester holds op_a/op_b/in_opcode steady until that edge, and the
  // consumer sees res_* stable from res_valid rising until it takes them.
  assign in_ready  = (r_state == IDLE) & ~rst;
  assign res_valid = (r_state == DONE);
  assign w_accept  = in_valid & in_ready;
  assign w_retire  = res_valid & res_ready;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_bypass ? DONE : SETTLE;
      SETTLE:  if (r_cnt == 4'd0) w_state_next = DONE;
      DONE:    if (w_retire) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 4'd0;
      sign1       <= 1'b0;
      sign2       <= 1'b0;
      exp1        <= 8'd0;
      exp2        <= 8'd0;
      sig1        <= 23'd0;
      sig2        <= 23'd0;
      opcode      <= 1'b0;
      res_bits    <= 32'd0;
      res_error   <= '0;
      res_bypass  <= 1'b0;
      res_invalid <= 1'b0;
    end else if (w_accept) begin
      sign1  <= w_a.unpkg.sign;
      exp1   <= w_a.unpkg.exponent;
      sig1   <= w_a.unpkg.significand;
      sign2  <= w_b.unpkg.sign;
      exp2   <= w_b.unpkg.exponent;
      sig2   <= w_b.unpkg.significand;
      opcode <= in_opcode;
      if (w_bypass) begin
        res_bits    <= w_byp.bits;
        res_error   <= '0;
        res_bypass  <= 1'b1;
        res_invalid <= w_byp.invalid;
      end else begin
        r_cnt <= CNT_INIT;
      end
    end else if (r_state == SETTLE) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd0) begin
        res_bits    <= fp_out;
        res_error   <= error;
        res_bypass  <= 1'b0;
        res_invalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Self-checking bench: vector table, randomized transactions against a
// reference model, backpressure and mid-flight reset sequences.
module tb_fp_addsub_sequencer;
  import addpkg::*;

  localparam int SC = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      op_a, op_b;
  logic             in_opcode;
  logic             sign1, sign2, opcode;
  logic [7:0]       exp1, exp2;
  logic [22:0]      sig1, sig2;
  logic [31:0]      fp_out;
  logic [ERR_W-1:0] error;
  logic             res_valid, res_ready;
  logic [31:0]      res_bits;
  logic [ERR_W-1:0] res_error;
  logic             res_bypass, res_invalid;
  seq_state_e       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Stand-in for add_sub_top: a known answer for 0.3+2.5, otherwise a
  // deterministic scramble of the operand fields.
  function automatic logic [31:0] stub_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic opc);
    if (a == 32'h3E99999A && b == 32'h40200000 && !opc) return 32'h40333333;
    return {a[31] ^ b[31] ^ opc, a[30:23] + b[30:23], a[22:0] ^ {b[11:0], b[22:12]}};
  endfunction

  function automatic logic [2:0] stub_err(input logic [31:0] a, input logic [31:0] b,
                                          input logic opc);
    return {a[23] ^ b[0], opc, a[31]};
  endfunction

  assign fp_out = stub_add({sign1, exp1, sig1}, {sign2, exp2, sig2}, opcode);
  assign error  = stub_err({sign1, exp1, sig1}, {sign2, exp2, sig2}, opcode);

  fp_addsub_sequencer #(.SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .in_opcode(in_opcode),
    .sign1(sign1), .sign2(sign2), .exp1(exp1), .exp2(exp2),
    .sig1(sig1), .sig2(sig2), .opcode(opcode),
    .fp_out(fp_out), .error(error),
    .res_valid(res_valid), .res_ready(res_ready), .res_bits(res_bits),
    .res_error(res_error), .res_bypass(res_bypass), .res_invalid(res_invalid),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic [31:0] bits;
    logic [2:0]  err;
    logic        byp;
    logic        inv;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        opc;
    exp_t        e;
  } vec_t;

  // Reference: special operands resolve immediately with IEEE results; all
  // others go through the adder and appear SC edges after acceptance.
  function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic opc);
    exp_t r;
    bit a_sp, b_sp, a_nan, b_nan;
    bit sb;
    a_sp  = (a[30:23] == 8'hFF);
    b_sp  = (b[30:23] == 8'hFF);
    a_nan = a_sp && (a[22:0] != 0);
    b_nan = b_sp && (b[22:0] != 0);
    sb    = b[31] ^ opc;
    if (!a_sp && !b_sp) begin
      r.bits = stub_add(a, b, opc); r.err = stub_err(a, b, opc);
      r.byp = 0; r.inv = 0; r.lat = SC + 1;
    end else begin
      r.err = 0; r.byp = 1; r.lat = 1;
      if (a_nan || b_nan)           begin r.bits = 32'h7FC00000; r.inv = 1; end
      else if (a_sp && b_sp)        begin
        if (a[31] != sb)            begin r.bits = 32'h7FC00000; r.inv = 1; end
        else                        begin r.bits = a;            r.inv = 0; end
      end
      else if (a_sp)                begin r.bits = a;                   r.inv = 0; end
      else                          begin r.bits = {sb, 31'h7F800000};  r.inv = 0; end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] f;
    f = $urandom;
    case ($urandom_range(0, 7))
      0:       return {f[31], 8'hFF, f[22:0] | 23'd1};
      1:       return {f[31], 8'hFF, 23'd0};
      2:       return {f[31], 31'd0};
      3:       return {f[31], 8'h00, f[22:0]};
      default: return {f[31], 8'(f[30:23] % 8'hFF), f[22:0]};
    endcase
  endfunction

  // One full transaction with `hold` cycles of result backpressure.
  task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic opc, input int hold, input exp_t e);
    int          w;
    int          lat;
    logic [7:0]  e1, e2;
    logic [31:0] held;
    @(negedge clk);
    op_a = a; op_b = b; in_opcode = opc; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    if (!in_ready) begin
      chk({tag, " accept_timeout"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 0; e1 = 0; e2 = 0;
    do begin
      @(negedge clk); lat++;
      if (lat == 1) begin e1 = exp1; e2 = exp2; end
    end while (!res_valid && lat < 40);
    if (!res_valid) begin
      chk({tag, " result_timeout"}, 32'(res_valid), 32'd1);
      return;
    end
    chk({tag, " latency"}, 32'(lat), 32'(e.lat));
    chk({tag, " exp1"}, 32'(e1), 32'(a[30:23]));
    chk({tag, " exp2"}, 32'(e2), 32'(b[30:23]));
    chk({tag, " res_bits"}, res_bits, e.bits);
    chk({tag, " res_error"}, 32'(res_error), 32'(e.err));
    chk({tag, " res_bypass"}, 32'(res_bypass), 32'(e.byp));
    chk({tag, " res_invalid"}, 32'(res_invalid), 32'(e.inv));
    held = res_bits;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " stall_valid"}, 32'(res_valid), 32'd1);
      chk({tag, " stall_bits"}, res_bits, held);
    end
    res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    chk({tag, " post_valid"}, 32'(res_valid), 32'd0);
    chk({tag, " post_ready"}, 32'(in_ready), 32'd1);
  endtask

  vec_t        vt[8];
  exp_t        e;
  logic [31:0] a, b, held;
  logic        opc;
  int          seen;
  int          w;

  initial begin
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    op_a = 0; op_b = 0; in_opcode = 0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst res_bits", res_bits, 32'd0);
    chk("rst operands", {sign1, sign2, opcode, exp1, exp2}, 32'd0);
    chk("rst sigs", {9'd0, sig1 | sig2}, 32'd0);
    chk("rst res_flags", {27'd0, res_error, res_bypass, res_invalid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst in_ready", 32'(in_ready), 32'd1);

    vt[0] = '{32'h3E99999A, 32'h40200000, 1'b0, '{32'h40333333, stub_err(32'h3E99999A, 32'h40200000, 1'b0), 1'b0, 1'b0, SC + 1}};
    vt[1] = '{32'h7F800000, 32'h3F800000, 1'b1, '{32'h7F800000, 3'd0, 1'b1, 1'b0, 1}};
    vt[2] = '{32'h7F800000, 32'h7F800000, 1'b1, '{32'h7FC00000, 3'd0, 1'b1, 1'b1, 1}};
    vt[3] = '{32'hFF800000, 32'h7F800000, 1'b1, '{32'hFF800000, 3'd0, 1'b1, 1'b0, 1}};
    vt[4] = '{32'h7FC00001, 32'h40000000, 1'b0, '{32'h7FC00000, 3'd0, 1'b1, 1'b1, 1}};
    vt[5] = '{32'h40000000, 32'hFF800000, 1'b1, '{32'h7F800000, 3'd0, 1'b1, 1'b0, 1}};
    vt[6] = '{32'h00000000, 32'h80000000, 1'b0, '{stub_add(32'h0, 32'h80000000, 1'b0), stub_err(32'h0, 32'h80000000, 1'b0), 1'b0, 1'b0, SC + 1}};
    vt[7] = '{32'h00012345, 32'h3F800000, 1'b1, '{stub_add(32'h00012345, 32'h3F800000, 1'b1), stub_err(32'h00012345, 32'h3F800000, 1'b1), 1'b0, 1'b0, SC + 1}};
    for (int i = 0; i < 8; i++)
      run_txn($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].opc, 0, vt[i].e);

    for (int i = 0; i < 150; i++) begin
      a = rand_op(); b = rand_op(); opc = 1'($urandom_range(0, 1));
      run_txn($sformatf("rnd%0d", i), a, b, opc, $urandom_range(0, 3), ref_model(a, b, opc));
    end

    // Stalled result while a new request waits upstream.
    @(negedge clk);
    op_a = 32'h3E99999A; op_b = 32'h40200000; in_opcode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    op_a = 32'h12345678; op_b = 32'h4ABCDEF0;
    w = 0;
    do begin @(negedge clk); w++; end while (!res_valid && w < 40);
    chk("bp valid", 32'(res_valid), 32'd1);
    held = res_bits;
    chk("bp bits", held, 32'h40333333);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp stall_valid", 32'(res_valid), 32'd1);
      chk("bp stall_bits", res_bits, held);
      chk("bp stall_in_ready", 32'(in_ready), 32'd0);
      chk("bp stall_exps", {16'd0, exp1, exp2}, 32'h00007D80);
    end
    in_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    chk("bp in_ready_after", 32'(in_ready), 32'd1);
    chk("bp valid_after", 32'(res_valid), 32'd0);

    // Reset one cycle into the adder wait.
    op_a = 32'h3E99999A; op_b = 32'h40200000; in_opcode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("mid_rst in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst res_bits", res_bits, 32'd0);
    chk("mid_rst operands", {sign1, sign2, opcode, exp1, exp2}, 32'd0);
    chk("mid_rst sigs", {9'd0, sig1 | sig2}, 32'd0);
    chk("mid_rst res_flags", {27'd0, res_error, res_bypass, res_invalid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst in_ready_after", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (res_valid) seen++;
      @(negedge clk);
    end
    chk("mid_rst no_result", 32'(seen), 32'd0);
    e = ref_model(32'h3E99999A, 32'h40200000, 1'b0);
    run_txn("after_rst", 32'h3E99999A, 32'h40200000, 1'b0, 1, e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
